counter_timp: RTL and testbench



---
 rtl/counter_timp.sv | 62 ++++++
 tb/tb_counter_timp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_timp.sv
// Hours:minutes time-of-day counter, one minute per TICKS_PER_MIN clocks, presettable from two sources.
// Outputs are registered; a load is visible one edge later, reset acts immediately.
module counter_timp #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] timp_ore1,
  input  logic [5:0] timp_minute1,
  input  logic [4:0] timp_ore2,
  input  logic [5:0] timp_minute2,
  input  logic       load_1,
  input  logic       load_2,
  output logic [4:0] ore,
  output logic [5:0] minute
);

  localparam int            PW         = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);

  logic [PW-1:0] presc;
  logic          valid_1;
  logic          valid_2;
  logic          presc_wrap;

  // Out-of-range presets are dropped so the time never leaves 00:00..23:59.
  assign valid_1    = (timp_ore1 <= 5'd23) && (timp_minute1 <= 6'd59);
  assign valid_2    = (timp_ore2 <= 5'd23) && (timp_minute2 <= 6'd59);
  assign presc_wrap = (presc == PRESC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      ore    <= '0;
      minute <= '0;
    end else if (load_1) begin
      // Any load request restarts the minute, even a rejected one.
      presc <= '0;
      if (valid_1) begin
        ore    <= timp_ore1;
        minute <= timp_minute1;
      end
    end else if (load_2) begin
      presc <= '0;
      if (valid_2) begin
        ore    <= timp_ore2;
        minute <= timp_minute2;
      end
    end else if (presc_wrap) begin
      presc <= '0;
      if (minute == 6'd59) begin
        minute <= '0;
        ore    <= (ore == 5'd23) ? 5'd0 : ore + 5'd1;
      end else begin
        minute <= minute + 6'd1;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_counter_timp.sv
// Scoreboarded bench: two instances (4 and 1 ticks per minute) share stimulus against a minutes-of-day model.
module tb_counter_timp;

  logic       clock;
  logic       reset;
  logic [4:0] timp_ore1, timp_ore2;
  logic [5:0] timp_minute1, timp_minute2;
  logic       load_1, load_2;
  logic [4:0] ore_a, ore_b;
  logic [5:0] minute_a, minute_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] exp_q[$];
  int          tod[2];
  int          pcnt[2];
  int          tpm[2] = '{4, 1};

  counter_timp #(.TICKS_PER_MIN(4)) u_dut_a (
    .clock(clock), .reset(reset),
    .timp_ore1(timp_ore1), .timp_minute1(timp_minute1),
    .timp_ore2(timp_ore2), .timp_minute2(timp_minute2),
    .load_1(load_1), .load_2(load_2),
    .ore(ore_a), .minute(minute_a)
  );

  counter_timp #(.TICKS_PER_MIN(1)) u_dut_b (
    .clock(clock), .reset(reset),
    .timp_ore1(timp_ore1), .timp_minute1(timp_minute1),
    .timp_ore2(timp_ore2), .timp_minute2(timp_minute2),
    .load_1(load_1), .load_2(load_2),
    .ore(ore_b), .minute(minute_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d (%b) want %0d:%0d", tag, obs[10:6], obs[5:0], obs,
               expv[10:6], expv[5:0]);
    end
  endtask

  function automatic logic [10:0] enc(input int t);
    logic [4:0] h;
    logic [5:0] m;
    h = 5'(t / 60);
    m = 6'(t % 60);
    return {h, m};
  endfunction

  function automatic logic [10:0] hm(input int h, input int m);
    return enc(h * 60 + m);
  endfunction

  // Reference: time kept as minutes since midnight, prescaler as a plain integer.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        tod[k]  = 0;
        pcnt[k] = 0;
      end else if (load_1) begin
        pcnt[k] = 0;
        if (timp_ore1 < 24 && timp_minute1 < 60) tod[k] = timp_ore1 * 60 + timp_minute1;
      end else if (load_2) begin
        pcnt[k] = 0;
        if (timp_ore2 < 24 && timp_minute2 < 60) tod[k] = timp_ore2 * 60 + timp_minute2;
      end else if (pcnt[k] + 1 >= tpm[k]) begin
        pcnt[k] = 0;
        tod[k]  = (tod[k] + 1) % 1440;
      end else begin
        pcnt[k] = pcnt[k] + 1;
      end
      exp_q.push_back(enc(tod[k]));
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    if (exp_q.size() < 2) begin
      chk({tag, "_qempty"}, 11'd0, 11'h7ff);
    end else begin
      chk({tag, "_a"}, {ore_a, minute_a}, exp_q.pop_front());
      chk({tag, "_b"}, {ore_b, minute_b}, exp_q.pop_front());
    end
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set1(input int h, input int m);
    timp_ore1    = 5'(h);
    timp_minute1 = 6'(m);
  endtask

  task automatic set2(input int h, input int m);
    timp_ore2    = 5'(h);
    timp_minute2 = 6'(m);
  endtask

  task automatic load1_once(input string tag, input int h, input int m);
    set1(h, m);
    load_1 = 1'b1;
    step(tag);
    load_1 = 1'b0;
  endtask

  initial begin
    tod  = '{0, 0};
    pcnt = '{0, 0};
    reset = 1'b1;
    load_1 = 1'b0;
    load_2 = 1'b0;
    set1(0, 0);
    set2(0, 0);
    #1;
    chk("reset_a", {ore_a, minute_a}, hm(0, 0));
    chk("reset_b", {ore_b, minute_b}, hm(0, 0));

    // Loads are ignored while reset is held.
    set1(12, 35);
    load_1 = 1'b1;
    steps("rst_hold", 2);
    load_1 = 1'b0;
    reset  = 1'b0;

    // Test plan 1
    steps("tp1", 8);
    chk("tp1_0002", {ore_a, minute_a}, hm(0, 2));

    // Test plan 2
    load1_once("tp2_load", 12, 35);
    chk("tp2_1235", {ore_a, minute_a}, hm(12, 35));
    steps("tp2_cnt", 3);
    chk("tp2_still", {ore_a, minute_a}, hm(12, 35));
    step("tp2_cnt");
    chk("tp2_1236", {ore_a, minute_a}, hm(12, 36));
    load_1 = 1'b1;
    steps("tp2_hold", 5);
    load_1 = 1'b0;
    chk("tp2_hold", {ore_a, minute_a}, hm(12, 35));

    // Test plan 3
    set2(7, 10);
    load_1 = 1'b1;
    load_2 = 1'b1;
    step("tp3_both");
    chk("tp3_prio", {ore_a, minute_a}, hm(12, 35));
    load_1 = 1'b0;
    step("tp3_l2");
    load_2 = 1'b0;
    chk("tp3_0710", {ore_a, minute_a}, hm(7, 10));

    // Test plan 4
    load1_once("tp4_load", 23, 58);
    steps("tp4_cnt", 4);
    chk("tp4_2359", {ore_a, minute_a}, hm(23, 59));
    steps("tp4_cnt", 4);
    chk("tp4_0000", {ore_a, minute_a}, hm(0, 0));
    load1_once("tp4_load2", 10, 59);
    steps("tp4_cnt2", 4);
    chk("tp4_1100", {ore_a, minute_a}, hm(11, 0));

    // Test plan 5
    load1_once("tp5_load", 5, 20);
    steps("tp5_pre", 2);
    set2(24, 10);
    load_2 = 1'b1;
    step("tp5_bad_h");
    set2(3, 60);
    step("tp5_bad_m");
    load_2 = 1'b0;
    chk("tp5_keep", {ore_a, minute_a}, hm(5, 20));
    steps("tp5_cnt", 3);
    chk("tp5_norun", {ore_a, minute_a}, hm(5, 20));
    step("tp5_cnt");
    chk("tp5_0521", {ore_a, minute_a}, hm(5, 21));

    // Test plan 6: asynchronous reset pulse between edges.
    load1_once("tp6_load", 14, 7);
    steps("tp6_pre", 2);
    chk("tp6_1407", {ore_a, minute_a}, hm(14, 7));
    reset = 1'b1;
    #1;
    chk("tp6_async_a", {ore_a, minute_a}, hm(0, 0));
    chk("tp6_async_b", {ore_b, minute_b}, hm(0, 0));
    reset = 1'b0;
    tod  = '{0, 0};
    pcnt = '{0, 0};
    steps("tp6_cnt", 3);
    chk("tp6_wait", {ore_a, minute_a}, hm(0, 0));
    step("tp6_cnt");
    chk("tp6_0001", {ore_a, minute_a}, hm(0, 1));

    // Random loads, including out-of-range presets.
    for (int i = 0; i < 300; i++) begin
      set1($urandom_range(0, 31), $urandom_range(0, 63));
      set2($urandom_range(0, 31), $urandom_range(0, 63));
      load_1 = ($urandom_range(0, 15) == 0);
      load_2 = ($urandom_range(0, 11) == 0);
      step("rand");
    end
    load_1 = 1'b0;
    load_2 = 1'b0;
    steps("tail", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
